// File: rtl/merge_lane_scheduler_pkg.sv
// Shared definitions for the modulation merge-lane scheduler: lane codes,
// lane count, FSM state encoding and a one-hot helper.
package merge_lane_scheduler_pkg;

  localparam int N_LANES = 4;

  localparam logic [1:0] QPSK   = 2'b00;
  localparam logic [1:0] QAM16  = 2'b01;
  localparam logic [1:0] QAM64  = 2'b10;
  localparam logic [1:0] QAM256 = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  function automatic logic [N_LANES-1:0] lane_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/merge_lane_scheduler_if.sv
// Lane-side and merged-output handshake bundle for the merge-lane scheduler.
// master = scheduler side, slave = lane buffers / framer side.
interface merge_lane_scheduler_if #(
  parameter int WIDTH = 3
);
  import merge_lane_scheduler_pkg::*;

  logic [N_LANES-1:0]                lane_req;
  logic [N_LANES-1:0]                lane_last;
  logic [N_LANES-1:0]                lane_ready;
  logic [N_LANES-1:0][4*WIDTH-1:0]   lane_data;
  logic                              out_ready;
  logic                              out_valid;
  logic [4*WIDTH-1:0]                out_data;
  logic [1:0]                        sel;
  logic [N_LANES-1:0]                grant;
  logic                              burst_done;
  logic                              cfg_fixed_en;
  logic [1:0]                        cfg_fixed_sel;

  modport master (
    input  lane_req, lane_last, lane_data, out_ready, cfg_fixed_en, cfg_fixed_sel,
    output lane_ready, out_valid, out_data, sel, grant, burst_done
  );

  modport slave (
    output lane_req, lane_last, lane_data, out_ready, cfg_fixed_en, cfg_fixed_sel,
    input  lane_ready, out_valid, out_data, sel, grant, burst_done
  );

endinterface

// File: rtl/merge_lane_scheduler_arb.sv
// Datapath helpers for the scheduler: a combinational 4-way round-robin
// picker and the 4:1 lane-word merge mux.
module rr_arbiter4
  import merge_lane_scheduler_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [1:0]         ptr,
  output logic [N_LANES-1:0] gnt_onehot,
  output logic [1:0]         gnt_idx
);

  logic       found;
  logic [1:0] cand;

  // Scan ptr+1, ptr+2, ptr+3, then ptr itself last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N_LANES; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt_idx    = cand;
        gnt_onehot = lane_onehot(cand);
      end
    end
  end

endmodule

module merge_mux4 #(
  parameter int W = 12
) (
  input  logic [3:0][W-1:0] din,
  input  logic [1:0]        sel,
  output logic [W-1:0]      dout
);

  assign dout = din[sel];

endmodule

// File: rtl/merge_lane_scheduler.sv
// Round-robin burst scheduler for the QPSK/QAM16/QAM64/QAM256 merge mux.
// Holds one lane for up to BURST_LEN words, then forces an IDLE bubble.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate eligible requests, register sel/grant
// ST_BURST | lane sel_q owns the mux; words flow while out_ready
module merge_lane_scheduler
  import merge_lane_scheduler_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int BURST_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  merge_lane_scheduler_if.master   bus
);

  localparam int              BCW       = $clog2(BURST_LEN) + 1;
  localparam logic [BCW-1:0]  BEAT_LAST = BCW'(BURST_LEN - 1);

  sched_state_e         state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [N_LANES-1:0]   grant_q, grant_d;
  logic                 burst_done_q, burst_done_d;
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;

  logic [N_LANES-1:0]   eligible;
  logic [N_LANES-1:0]   arb_gnt;
  logic [1:0]           arb_idx;
  logic                 owner_req;
  logic                 owner_last;
  logic                 xfer;
  logic                 out_valid_c;
  logic [N_LANES-1:0]   lane_ready_c;

  // Fixed mode masks everything but the locked lane before arbitration.
  assign eligible = bus.cfg_fixed_en ? (bus.lane_req & lane_onehot(bus.cfg_fixed_sel))
                                     : bus.lane_req;

  rr_arbiter4 u_arb (
    .req        (eligible),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign owner_req  = bus.lane_req[sel_q];
  assign owner_last = bus.lane_last[sel_q];

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grant_d      = grant_q;
    burst_done_d = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    out_valid_c  = 1'b0;
    lane_ready_c = '0;
    xfer         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          sel_d      = arb_idx;
          grant_d    = arb_gnt;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        // Gating with rst keeps the in-flight word from being accepted.
        out_valid_c  = owner_req && !rst;
        lane_ready_c = (bus.out_ready && !rst) ? lane_onehot(sel_q) : '0;
        xfer         = owner_req && bus.out_ready;
        if (!owner_req || (xfer && (owner_last || beat_cnt_q == BEAT_LAST))) begin
          state_d      = ST_IDLE;
          rr_ptr_d     = sel_q;
          beat_cnt_d   = '0;
          grant_d      = '0;
          burst_done_d = 1'b1;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= QPSK;
      grant_q      <= '0;
      burst_done_q <= 1'b0;
      beat_cnt_q   <= '0;
      rr_ptr_q     <= QAM256;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      burst_done_q <= burst_done_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  merge_mux4 #(.W(4 * WIDTH)) u_mux (
    .din  (bus.lane_data),
    .sel  (sel_q),
    .dout (bus.out_data)
  );

  assign bus.out_valid  = out_valid_c;
  assign bus.lane_ready = lane_ready_c;
  assign bus.sel        = sel_q;
  assign bus.grant      = grant_q;
  assign bus.burst_done = burst_done_q;

endmodule
